// File: rtl/compare_mon_pkg.sv
// Shared constants for the comparator result monitor: counter width default,
// FSM state encoding and readout beat indices.
package compare_mon_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DUMP = 1'b1;

  localparam logic [1:0] IDX_G   = 2'd0;
  localparam logic [1:0] IDX_S   = 2'd1;
  localparam logic [1:0] IDX_E   = 2'd2;
  localparam logic [1:0] IDX_ERR = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/compare_result_monitor.sv
// Counts Greater/Smaller/Equal/malformed comparator results and dumps a
// snapshot of the four counters as four registered beats on request.
module compare_result_monitor
  import compare_mon_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             greater,
  input  logic             smaller,
  input  logic             equal,
  input  logic             clear,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [1:0]       rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             onehot_err
);

  logic             w_one;
  logic [3:0]       w_inc;
  logic [CNT_W-1:0] w_cnt [4];
  logic [1:0]       w_next_beat;

  logic [0:0]       r_state;
  logic [1:0]       r_beat;
  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;
  logic             r_onehot_err;
  logic [CNT_W-1:0] r_snap [4];

  assign w_one          = $onehot({equal, smaller, greater});
  assign w_inc[IDX_G]   = in_valid & w_one & greater;
  assign w_inc[IDX_S]   = in_valid & w_one & smaller;
  assign w_inc[IDX_E]   = in_valid & w_one & equal;
  assign w_inc[IDX_ERR] = in_valid & ~w_one;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clear),
        .inc     (w_inc[gi]),
        .count   (w_cnt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_onehot_err <= 1'b0;
    end else if (clear) begin
      r_onehot_err <= 1'b0;
    end else if (w_inc[IDX_ERR]) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign w_next_beat = r_beat + 2'd1;

  // r_beat doubles as rd_idx; it is forced back to 0 whenever no beat is shown
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= IDX_G;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rd_req) begin
            for (int i = 0; i < 4; i++) r_snap[i] <= w_cnt[i];
            r_state    <= ST_DUMP;
            r_beat     <= IDX_G;
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_cnt[IDX_G];
          end
        end
        ST_DUMP: begin
          if (r_beat == IDX_ERR) begin
            r_state    <= ST_IDLE;
            r_beat     <= IDX_G;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
          end else begin
            r_beat     <= w_next_beat;
            r_rd_data  <= r_snap[w_next_beat];
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_beat     <= IDX_G;
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end
      endcase
    end
  end

  assign rd_valid   = r_rd_valid;
  assign busy       = r_rd_valid;
  assign rd_idx     = r_beat;
  assign rd_data    = r_rd_data;
  assign onehot_err = r_onehot_err;

endmodule

// File: tb/tb_compare_result_monitor.sv
// Randomised and directed bench for compare_result_monitor against a
// queue-based behavioural model of counting, saturation and readout bursts.
module tb_compare_result_monitor;

  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          greater = 1'b0;
  logic          smaller = 1'b0;
  logic          equal = 1'b0;
  logic          clear = 1'b0;
  logic          rd_req = 1'b0;
  logic          rd_valid;
  logic [1:0]    rd_idx;
  logic [CW-1:0] rd_data;
  logic          busy;
  logic          onehot_err;

  compare_result_monitor #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .greater    (greater),
    .smaller    (smaller),
    .equal      (equal),
    .clear      (clear),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .busy       (busy),
    .onehot_err (onehot_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  int m_cnt [4];
  bit m_err;
  int q_idx  [$];
  int q_data [$];
  bit e_valid;
  int e_idx;
  int e_data;

  wire [12:0] obs_vec = {rd_valid, busy, rd_idx, rd_data, onehot_err};

  function automatic logic [12:0] exp_vec();
    logic [1:0]    idx;
    logic [CW-1:0] dat;
    idx = e_idx[1:0];
    dat = e_data[CW-1:0];
    return {e_valid, e_valid, idx, dat, m_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_err = 0;
    q_idx.delete();
    q_data.delete();
    e_valid = 0;
    e_idx = 0;
    e_data = 0;
  endtask

  task automatic bump(input int k);
    if (m_cnt[k] < MAX) m_cnt[k]++;
  endtask

  // Drive at negedge, model the posedge, return at the following negedge.
  task automatic step(input bit v, input bit g, input bit s, input bit e,
                      input bit c, input bit r);
    int nf;
    in_valid = v; greater = g; smaller = s; equal = e; clear = c; rd_req = r;
    @(posedge clk);
    if (r && q_idx.size() == 0 && !e_valid) begin
      for (int i = 0; i < 4; i++) begin
        q_idx.push_back(i);
        q_data.push_back(m_cnt[i]);
      end
    end
    if (q_idx.size() > 0) begin
      e_valid = 1;
      e_idx = q_idx.pop_front();
      e_data = q_data.pop_front();
    end else begin
      e_valid = 0; e_idx = 0; e_data = 0;
    end
    if (c) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_err = 0;
    end else if (v) begin
      nf = int'(g) + int'(s) + int'(e);
      if (nf == 1) bump(g ? 0 : (s ? 1 : 2));
      else begin
        bump(3);
        m_err = 1;
      end
    end
    @(negedge clk);
    in_valid = 0; greater = 0; smaller = 0; equal = 0; clear = 0; rd_req = 0;
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs_vec !== 13'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h expected %h", obs_vec, 13'd0);
    end
    reset_n = 1;
    step(0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_release: got %h expected %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_count_readout();
    int beats [4];
    int nb = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, i < 3, (i == 3) || (i == 4), i == 5, 0, 0);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL count_step%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, i == 0);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL count_dump%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (rd_valid === 1'b1) begin
        beats[rd_idx] = int'(rd_data);
        nb++;
      end
    end
    n_vec++;
    if (nb != 4 || beats[0] != 3 || beats[1] != 2 || beats[2] != 1 ||
        beats[3] != 0 || onehot_err !== 1'b0) begin
      n_err++;
      $display("FAIL count_beats: got n=%0d %0d,%0d,%0d,%0d err=%b expected n=4 3,2,1,0 err=0",
               nb, beats[0], beats[1], beats[2], beats[3], onehot_err);
    end
  endtask

  task automatic test_malformed();
    int err_beat = -1;
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 0, i == 3);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL malformed_hold%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (rd_valid === 1'b1 && rd_idx === 2'd3) err_beat = int'(rd_data);
    end
    n_vec++;
    if (err_beat != 2 || onehot_err !== 1'b1) begin
      n_err++;
      $display("FAIL malformed_err: got cnt=%0d flag=%b expected cnt=2 flag=1", err_beat, onehot_err);
    end
    step(0, 0, 0, 0, 1, 0);
    n_vec++;
    if (onehot_err !== 1'b0 || obs_vec !== exp_vec()) begin
      n_err++;
      $display("FAIL malformed_clear: got %h expected %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_saturation();
    int beats [4];
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 0, 1, 0, 0);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL sat_step%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) beats[i] = -1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, i == 0);
      if (rd_valid === 1'b1) beats[rd_idx] = int'(rd_data);
    end
    n_vec++;
    if (beats[0] != 0 || beats[1] != 0 || beats[2] != 255 || beats[3] != 0) begin
      n_err++;
      $display("FAIL sat_beats: got %0d,%0d,%0d,%0d expected 0,0,255,0",
               beats[0], beats[1], beats[2], beats[3]);
    end
  endtask

  task automatic test_dump_ignore();
    int nb = 0;
    int e_beat = -1;
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    if (rd_valid === 1'b1) nb++;
    for (int i = 0; i < 8; i++) begin
      step(i < 4, 0, 0, i < 4, 0, i < 4);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL ignore_step%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (rd_valid === 1'b1) nb++;
    end
    n_vec++;
    if (nb != 4) begin
      n_err++;
      $display("FAIL ignore_burst: got %0d beats expected 4", nb);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, i == 0);
      if (rd_valid === 1'b1 && rd_idx === 2'd2) e_beat = int'(rd_data);
    end
    n_vec++;
    if (e_beat != 4) begin
      n_err++;
      $display("FAIL ignore_next: got E=%0d expected 4", e_beat);
    end
  endtask

  task automatic test_back_to_back();
    int nb = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b_step%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (rd_valid === 1'b1) nb++;
    end
    n_vec++;
    if (nb != 8) begin
      n_err++;
      $display("FAIL b2b_beats: got %0d expected 8", nb);
    end
    repeat (4) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_dump();
    int nb = 0;
    int sum = 0;
    step(0, 0, 0, 0, 1, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    reset_n = 0;
    #1;
    model_reset();
    n_vec++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || obs_vec !== 13'd0) begin
      n_err++;
      $display("FAIL abort_async: got %h expected %h", obs_vec, 13'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) nb++;
    end
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (rd_valid === 1'b1) nb++;
    end
    n_vec++;
    if (nb != 0) begin
      n_err++;
      $display("FAIL abort_nobeats: got %0d expected 0", nb);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, i == 0);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL abort_read%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (rd_valid === 1'b1) begin
        nb++;
        sum += int'(rd_data);
      end
    end
    n_vec++;
    if (nb != 4 || sum != 0) begin
      n_err++;
      $display("FAIL abort_zero: got n=%0d sum=%0d expected n=4 sum=0", nb, sum);
    end
  endtask

  task automatic test_random();
    bit [2:0] f;
    for (int i = 0; i < 600; i++) begin
      f = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, f[0], f[1], f[2],
           $urandom_range(0, 60) == 0, $urandom_range(0, 5) == 0);
      n_vec++;
      if (obs_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_readout();
    test_malformed();
    test_saturation();
    test_dump_ignore();
    test_back_to_back();
    test_reset_mid_dump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/compare_result_monitor.md
COMPARE_RESULT_MONITOR -- requirements
Module: compare_result_monitor

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of every counter and of rd_data.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state updates on posedge clk.
REQ-003 Port reset_n, input, 1: SHALL be the asynchronous, active-low reset.
REQ-004 Port in_valid, input, 1: SHALL qualify greater/smaller/equal as one comparison result this cycle.
REQ-005 Ports greater, smaller, equal, input, 1 each: SHALL carry the registered Greater/Smaller/Equal outputs of the upstream 6-bit comparator.
REQ-006 Port clear, input, 1: SHALL be a synchronous clear of the statistics.
REQ-007 Port rd_req, input, 1: SHALL be a single-cycle readout request.
REQ-008 Port rd_valid, output, 1: SHALL mark a valid readout beat.
REQ-009 Port rd_idx, output, 2: SHALL identify the beat: 0=G, 1=S, 2=E, 3=ERR.
REQ-010 Port rd_data, output, CNT_W: SHALL carry the snapshot count for rd_idx.
REQ-011 Port busy, output, 1: SHALL be high while a readout is in progress.
REQ-012 Port onehot_err, output, 1: SHALL be a sticky flag for any malformed result.

Function
REQ-013 On an edge with in_valid=1 and exactly one of greater/smaller/equal high, the block SHALL increment the matching counter (cnt_g, cnt_s or cnt_e) by 1.
REQ-014 On an edge with in_valid=1 and zero or more than one flag high, the block SHALL increment cnt_err and set onehot_err.
REQ-015 With in_valid=0, the flag inputs SHALL be ignored.
REQ-016 Every counter SHALL saturate at 2^CNT_W-1; it SHALL neither wrap nor change other counters.
REQ-017 With clear=1, all four counters and onehot_err SHALL be 0 after the edge; clear SHALL take priority over a same-cycle sample, which is discarded.
REQ-018 The FSM SHALL have two states: IDLE and DUMP, with a 2-bit beat index.
REQ-019 IDLE + rd_req=1: the block SHALL copy all four counters into a snapshot (values before this edge's update), set beat index 0 and enter DUMP.
REQ-020 In DUMP: rd_valid=1, rd_idx = beat index, rd_data = snapshot[beat index]; the index SHALL advance 0->1->2->3 each cycle; after beat 3 the FSM SHALL return to IDLE.
REQ-021 Latency: rd_req sampled at edge k SHALL produce exactly four rd_valid beats, in the cycles following edges k .. k+3; busy SHALL equal rd_valid.
REQ-022 rd_req while in DUMP SHALL be ignored; no queueing.
REQ-023 rd_req on the edge where DUMP returns to IDLE SHALL be ignored; a new request is accepted from the next IDLE cycle.
REQ-024 Counting and clear SHALL continue during DUMP; they SHALL NOT alter the snapshot being read out.
REQ-025 When rd_valid=0, rd_idx and rd_data SHALL be 0.
REQ-026 There SHALL be no combinational path from any input to any output; all outputs come from registers.

Reset
REQ-027 reset_n=0 SHALL immediately zero all counters, snapshot, onehot_err, rd_valid, rd_idx, rd_data and busy, and force IDLE.
REQ-028 Reset asserted mid-DUMP SHALL abort the readout with no further beats.
REQ-029 Release of reset_n SHALL take effect at the first posedge clk after deassertion.

Structure
REQ-030 Package compare_mon_pkg SHALL hold the CNT_W default, the state encoding (IDLE, DUMP) and the index constants IDX_G=0, IDX_S=1, IDX_E=2, IDX_ERR=3.
REQ-031 One sub-module, sat_counter, SHALL be used: inputs clk, reset_n, clr, inc; output count; saturating. Instantiate it four times.

Verification
REQ-032 Apply 3 cycles of (1,0,0), 2 of (0,1,0) and 1 of (0,0,1) with in_valid=1, then rd_req -> beats 3, 2, 1, 0 on idx 0..3; onehot_err=0.
REQ-033 Apply in_valid=1 with (1,1,0), then (0,0,0) -> cnt_err=2, onehot_err=1 and held; a following clear -> all counts 0 and onehot_err=0.
REQ-034 Apply 300 cycles of equal=1 with CNT_W=8 -> E beat = 255; G, S and ERR beats = 0.
REQ-035 Apply rd_req, then equal samples and rd_req again during DUMP -> only the four original snapshot beats appear, with no second burst; the new samples show on the next readout.
REQ-036 Assert reset_n=0 in the cycle after beat 1 -> rd_valid drops asynchronously, no beats 2/3 appear, and a later readout returns all zeros.
